// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch queue.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam int IMM_BIT = 15;
  localparam logic [31:0] RESET_PC = 32'h20;

  typedef struct packed {
    logic [31:0]       pc;
    logic [WORD_W-1:0] instr;
  } entry_t;

  function automatic logic is_long(
    input logic [WORD_W-1:0] w
  );
    return w[IMM_BIT];
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Valid/ready instruction stream bundle (pc, word, immediate).
interface fetch_queue_if;
  import fetch_pkg::*;

  logic              valid;
  logic              ready;
  logic [31:0]       pc;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] imm;

  modport master (
    output valid, pc, instr, imm,
    input  ready
  );

  modport slave (
    input  valid, pc, instr, imm,
    output ready
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: one write port, async reads at head and head+1.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata0_o,
  output entry_t        rdata1_o
);

  entry_t mem_q [DEPTH];
  logic [AW-1:0] raddr1;

  // Pointer width equals log2(DEPTH), so +1 wraps for free.
  assign raddr1 = raddr_i + AW'(1);
  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue for 16/32-bit instructions; FETCH_QUEUE_BYPASS_EN adds
// a same-cycle path for single-word words into an empty queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [31:0]       i_pc,
  input  logic [WORD_W-1:0] i_instr,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_pc,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_imm,
  output logic [CW-1:0]     o_count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pop_n;

  entry_t head, nxt, wdata;
  logic head_long, q_valid;
  logic byp, push, pop;

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (i_clk),
    .we_i     (push),
    .waddr_i  (wr_q),
    .wdata_i  (wdata),
    .raddr_i  (rd_q),
    .rdata0_o (head),
    .rdata1_o (nxt)
  );

  assign wdata = '{pc: i_pc, instr: i_instr};
  assign head_long = is_long(head.instr);
  assign o_ready = (cnt_q != FULL);
  assign o_count = cnt_q;

  // A two-word head is only complete once its immediate is queued.
  assign q_valid = !i_flush &&
    ((cnt_q >= TWO) ||
     (cnt_q == ONE && !head_long));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (cnt_q == '0) && i_valid &&
    !i_flush && !is_long(i_instr);
`else
  assign byp = 1'b0;
`endif

  assign o_valid = q_valid | byp;
  assign pop = q_valid && i_ready;
  assign push = i_valid && o_ready &&
    !i_flush && !(byp && i_ready);

  always_comb begin
    pop_n = '0;
    if (pop) begin
      pop_n = head_long ? TWO : ONE;
    end
  end

  always_comb begin
    rd_d = rd_q + pop_n[AW-1:0];
    wr_d = wr_q + AW'(push);
    cnt_d = cnt_q + CW'(push) - pop_n;
    if (i_flush) begin
      rd_d = '0;
      wr_d = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    o_pc = '0;
    o_instr = '0;
    o_imm = '0;
    if (byp) begin
      o_pc = i_pc;
      o_instr = i_instr;
    end else if (cnt_q != '0) begin
      o_pc = head.pc;
      o_instr = head.instr;
      if (head_long && cnt_q >= TWO) begin
        o_imm = nxt.instr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 16-bit word entries (power of two, >=2).
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_valid  input  1  instruction-memory word valid this cycle.
REQ-005 SHALL have port i_pc  input  32  PC of the incoming word.
REQ-006 SHALL have port i_instr  input  16  incoming instruction word.
REQ-007 SHALL have port o_ready  output  1  queue can accept a word (not full); drives the program-counter enable.
REQ-008 SHALL have port i_flush  input  1  discard all queued words (branch, interrupt, reset vector).
REQ-009 SHALL have port o_valid  output  1  complete instruction at head.
REQ-010 SHALL have port i_ready  input  1  decode accepts head instruction.
REQ-011 SHALL have port o_pc  output  32  PC of head instruction's first word.
REQ-012 SHALL have port o_instr  output  16  head instruction word.
REQ-013 SHALL have port o_imm  output  16  immediate word; 0 when head is single-word.
REQ-014 SHALL have port o_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL store {pc, instr} per entry in a circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL write on a rising edge when i_valid && o_ready && !i_flush.
REQ-017 SHALL drive o_ready = (o_count != DEPTH).
REQ-018 SHALL treat a head word with bit 15 set as a two-word instruction whose next entry is its immediate.
REQ-019 SHALL assert o_valid when count>=1 and head bit15=0, or count>=2 and head bit15=1.
REQ-020 SHALL pop 1 entry (single-word) or 2 entries (two-word) on a rising edge with o_valid && i_ready.
REQ-021 SHALL update count as count + push - pop in the same cycle when both occur; full-and-pop with simultaneous push is allowed only if o_ready was high.
REQ-022 SHALL give one-cycle latency: a word written at edge N is visible at head after edge N.
REQ-023 SHALL, on i_flush, set pointers and count to 0 at the next edge; flush wins over simultaneous push and pop.
REQ-024 SHALL deassert o_valid combinationally while i_flush is high.
REQ-025 SHALL never overwrite an unread entry and never pop when o_valid is low.

Reset
REQ-026 SHALL, on i_reset_n low, asynchronously clear pointers and count; o_valid=0, o_count=0, o_ready=1, o_pc=0, o_instr=0, o_imm=0.
REQ-027 SHALL discard any partially buffered two-word instruction when reset asserts mid-operation.

Configuration
REQ-028 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-029 SHALL, with the macro defined, present an incoming single-word instruction combinationally on the outputs when the queue is empty, i_valid=1 and i_flush=0, and not store it if i_ready=1 that cycle.
REQ-030 SHALL, without the macro, always use REQ-022 latency with no combinational i_* to o_valid path.

Structure
REQ-031 SHALL take word width 16, immediate-flag bit index 15 and reset PC 32'h20 from shared package fetch_pkg.
REQ-032 SHALL place the storage array in one sub-module fetch_queue_ram (1 write port, 2 async read ports: head and head+1).

Verification
REQ-033 Reset: drive i_reset_n=0 mid-stream with 3 entries -> o_count=0, o_valid=0, o_ready=1 immediately.
REQ-034 Single-word: push pc=0x20 instr=0x1234, i_ready=1 -> next cycle o_valid=1, o_pc=0x20, o_instr=0x1234, o_imm=0, then empty.
REQ-035 Two-word: push 0x8001 at 0x21 with i_ready=1, o_valid stays 0 until push 0xBEEF at 0x22 -> next cycle o_instr=0x8001, o_imm=0xBEEF, o_pc=0x21, pop 2.
REQ-036 Full: i_ready=0, push 4 words -> o_count=4, o_ready=0; 5th word not stored; pointers wrap correctly after draining and refilling 4 more.
REQ-037 Flush: 3 entries, simultaneous i_flush, push and pop -> next cycle o_count=0, pushed word absent.
REQ-038 Bypass (macro defined): empty queue, push 0x0042 with i_ready=1 -> same cycle o_valid=1, o_instr=0x0042, o_count stays 0.
